sif_xa_arbiter: RTL and testbench
=================================

# sif_xa_arbiter

Shares the single SIF XA slave port between `N_REQ` independent requesters using round-robin arbitration. It sequences each transaction onto the XA strobes (`xa_wr_s`, `xa_rd_s`) and captures the read data the SIF returns one cycle after the read strobe. It routes that data back to the issuing requester. It sits between the testbench or host-side masters and the SIF DUT, and replaces direct single-driver access to the XA port. The WA port is not touched.

## Interface
Parameters:
- `N_REQ`, 4 — number of requesters, 2..8.
- `AW`, 16 — XA address width.
- `DW`, 16 — XA data width.

Ports:
- `clk`  in  1  — single clock; all logic rising-edge.
- `rst`  in  1  — asynchronous, active-high reset.
- `req_valid`  in  N_REQ  — requester i has a pending transaction.
- `req_we`  in  N_REQ  — 1 = write, 0 = read, per requester.
- `req_addr`  in  N_REQ*AW  — packed addresses; requester i at `[i*AW +: AW]`.
- `req_wdata`  in  N_REQ*DW  — packed write data.
- `grant`  out  N_REQ  — one-hot; 1-cycle pulse, coincident with the XA strobe.
- `rsp_valid`  out  N_REQ  — one-hot; 1-cycle pulse, read data ready for requester i.
- `rsp_rdata`  out  DW  — read data; valid only while any `rsp_valid` bit is high.
- `xa_addr`  out  AW  — to SIF.
- `xa_data_wr`  out  DW  — to SIF.
- `xa_wr_s`  out  1  — write strobe to SIF.
- `xa_rd_s`  out  1  — read strobe to SIF.
- `xa_data_rd`  in  DW  — from SIF; valid in the cycle after `xa_rd_s`.
- `busy`  out  1  — high in ISSUE and RD_WAIT.

## Operation
- FSM states: IDLE, ISSUE, RD_WAIT.
- **IDLE**
  - If any `req_valid` bit is high at the clock edge, pick winner w = first set bit searching from `last+1` upward, mod N_REQ.
  - Register `xa_addr`/`xa_data_wr` from requester w.
  - Register `xa_wr_s` = `req_we[w]` and `xa_rd_s` = !`req_we[w]`, with `grant[w]` = 1.
  - Set `last` = w, go to ISSUE.
- **ISSUE** (strobe cycle): at the next edge, strobes and `grant` clear.
  - Write: go to IDLE.
  - Read: go to RD_WAIT.
- **RD_WAIT**: at the edge, register `rsp_rdata` = `xa_data_rd` and `rsp_valid[w]` = 1, go to IDLE.
  - `rsp_valid` clears after 1 cycle.
  - Arbitration in IDLE runs concurrently with that pulse.
- **Requester rule**: hold `req_*` stable from `req_valid` rise through the grant cycle. Drop `req_valid` at the edge that ends the grant cycle, or keep it high with new fields for the next transaction.
- `xa_addr`/`xa_data_wr` hold their last value outside ISSUE. Strobes are never both high.
- The arbiter never issues while in ISSUE or RD_WAIT, so there is at most one XA transaction outstanding.
- Round-robin pointer wraps from N_REQ-1 to 0.
  - A lone requester may win consecutively.
  - With all requesters valid, no requester waits more than N_REQ-1 grants.
- **Reset** (async assert, any state):
  - state = IDLE, `last` = N_REQ-1 (requester 0 highest after reset).
  - All outputs 0: `grant`, `rsp_valid`, `rsp_rdata`, `xa_addr`, `xa_data_wr`, `xa_wr_s`, `xa_rd_s`, `busy`.
  - An in-flight read is dropped with no `rsp_valid`.

## Timing
- Request sampled at edge E0. Grant and strobe are high in cycle E0→E1.
- Write latency: 1 cycle from sampling edge to strobe. Throughput is 1 write per 2 cycles.
- Read: strobe in cycle S, SIF data in S+1, `rsp_valid`/`rsp_rdata` in S+2. Throughput is 1 read per 3 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset deassertion is synchronised externally; the first arbitration occurs at the first edge with `rst` low.

## Structure
- Shared package `sif_arb_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} arb_state_t`.
  - Default widths `SIF_AW` = 16 and `SIF_DW` = 16.
- Sub-module `rr_picker #(N)`:
  - Inputs: `req`, `last`.
  - Outputs: one-hot `gnt` and index `idx`.
  - Purely combinational, instantiated once.
- The top level holds the FSM, the `last` register and the output registers.

## Test plan
- **Single write.** Requester 2 writes addr 0x0010, data 0xBEEF. Expect `grant` = 0b0100 and `xa_wr_s` high for exactly 1 cycle with `xa_addr` = 0x0010, `xa_data_wr` = 0xBEEF. Expect no `rsp_valid`.
- **Single read.** Requester 1 reads 0x0020 and the SIF model returns 0x1234 in S+1. Expect `xa_rd_s` in S, then `rsp_valid` = 0b0010 with `rsp_rdata` = 0x1234 in S+2.
- **All requesters at once after reset.** All 4 requesters write simultaneously and stay valid. Expect grant order 0, 1, 2, 3, 0 with grants 2 cycles apart.
- **Wrap with a sparse set.** Only requesters 3 and 0 valid, `last` = 3. Expect 0 granted, then 3, then 0.
- **Reset mid-read.** Assert `rst` during RD_WAIT. Expect all outputs 0 immediately and no `rsp_valid` for the dropped read. The next grant after release goes to the lowest valid index.
- **Mixed back-to-back.** Requester 0 writes 0x0001 and requester 1 reads 0x0001 in the same cycle. Expect the write strobe first, the read strobe 2 cycles later, and `rsp_rdata` equal to the written value.

Source files
------------

// File: rtl/sif_arb_pkg.sv
// Shared types and default widths for the SIF XA port arbiter.
package sif_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} arb_state_t;

  localparam int unsigned SIF_AW = 16;
  localparam int unsigned SIF_DW = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit after 'last', wrapping.
module rr_picker #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int unsigned c;
  logic        found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    c     = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      c = (32'(last) + k) % N;
      if (!found && req[c]) begin
        found  = 1'b1;
        idx    = IW'(c);
        gnt[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sif_xa_arbiter.sv
// Round-robin arbiter sharing the SIF XA slave port among N_REQ requesters,
// sequencing strobes and routing read data back to the issuing requester.
module sif_xa_arbiter
  import sif_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned AW    = SIF_AW,
  parameter int unsigned DW    = SIF_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_we,
  input  logic [N_REQ*AW-1:0] req_addr,
  input  logic [N_REQ*DW-1:0] req_wdata,
  output logic [N_REQ-1:0]    grant,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic [AW-1:0]       xa_addr,
  output logic [DW-1:0]       xa_data_wr,
  output logic                xa_wr_s,
  output logic                xa_rd_s,
  input  logic [DW-1:0]       xa_data_rd,
  output logic                busy
);

  localparam int unsigned LW = $clog2(N_REQ);

  arb_state_t       state_q, state_d;
  logic [LW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [AW-1:0]    xa_addr_q, xa_addr_d;
  logic [DW-1:0]    xa_data_wr_q, xa_data_wr_d;
  logic             xa_wr_s_q, xa_wr_s_d;
  logic             xa_rd_s_q, xa_rd_s_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [LW-1:0]    pick_idx;

  rr_picker #(.N(N_REQ)) u_picker (
    .req  (req_valid),
    .last (last_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_q       <= LW'(N_REQ - 1);
      grant_q      <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
      xa_addr_q    <= '0;
      xa_data_wr_q <= '0;
      xa_wr_s_q    <= 1'b0;
      xa_rd_s_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      grant_q      <= grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      xa_addr_q    <= xa_addr_d;
      xa_data_wr_q <= xa_data_wr_d;
      xa_wr_s_q    <= xa_wr_s_d;
      xa_rd_s_q    <= xa_rd_s_d;
      busy_q       <= busy_d;
    end
  end

  // last_q doubles as the owner of the outstanding read while in ISSUE/RD_WAIT.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    grant_d      = '0;
    rsp_valid_d  = '0;
    rsp_rdata_d  = rsp_rdata_q;
    xa_addr_d    = xa_addr_q;
    xa_data_wr_d = xa_data_wr_q;
    xa_wr_s_d    = 1'b0;
    xa_rd_s_d    = 1'b0;
    busy_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d      = ISSUE;
          last_d       = pick_idx;
          grant_d      = pick_gnt;
          xa_addr_d    = req_addr[pick_idx*AW +: AW];
          xa_data_wr_d = req_wdata[pick_idx*DW +: DW];
          xa_wr_s_d    = req_we[pick_idx];
          xa_rd_s_d    = !req_we[pick_idx];
          busy_d       = 1'b1;
        end
      end
      ISSUE: begin
        state_d = xa_wr_s_q ? IDLE : RD_WAIT;
        busy_d  = !xa_wr_s_q;
      end
      RD_WAIT: begin
        state_d             = IDLE;
        rsp_rdata_d         = xa_data_rd;
        rsp_valid_d[last_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign grant      = grant_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign xa_addr    = xa_addr_q;
  assign xa_data_wr = xa_data_wr_q;
  assign xa_wr_s    = xa_wr_s_q;
  assign xa_rd_s    = xa_rd_s_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sif_xa_arbiter.sv
// Directed self-checking bench for sif_xa_arbiter with a small SIF XA memory model.
module tb_sif_xa_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    grant, rsp_valid;
  logic [DW-1:0]   rsp_rdata, xa_data_wr, xa_data_rd;
  logic [AW-1:0]   xa_addr;
  logic            xa_wr_s, xa_rd_s, busy;

  int errors = 0;
  int checks = 0;

  sif_xa_arbiter #(.N_REQ(N), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .grant      (grant),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .xa_addr    (xa_addr),
    .xa_data_wr (xa_data_wr),
    .xa_wr_s    (xa_wr_s),
    .xa_rd_s    (xa_rd_s),
    .xa_data_rd (xa_data_rd),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // SIF model: writes land at the strobe edge, read data appears the cycle after xa_rd_s.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (xa_wr_s) mem[xa_addr[7:0]] <= xa_data_wr;
    if (xa_rd_s) xa_data_rd <= (xa_addr == 16'h0020) ? 16'h1234 : mem[xa_addr[7:0]];
  end

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[i]            = we;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    checks++; if (grant !== 4'b0) begin errors++; $display("FAIL reset_grant: got %b expected 0000", grant); end
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0000", rsp_rdata); end
    checks++; if (xa_addr !== 16'h0) begin errors++; $display("FAIL reset_xa_addr: got %h expected 0000", xa_addr); end
    checks++; if (xa_data_wr !== 16'h0) begin errors++; $display("FAIL reset_xa_data_wr: got %h expected 0000", xa_data_wr); end
    checks++; if ({xa_wr_s, xa_rd_s, busy} !== 3'b000) begin errors++; $display("FAIL reset_strobes_busy: got %b expected 000", {xa_wr_s, xa_rd_s, busy}); end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    set_req(2, 1'b1, 16'h0010, 16'hBEEF);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL wr_grant: got %b expected 0100", grant); end
    checks++; if ({xa_wr_s, xa_rd_s, busy} !== 3'b101) begin errors++; $display("FAIL wr_strobes: got %b expected 101", {xa_wr_s, xa_rd_s, busy}); end
    checks++; if ({xa_addr, xa_data_wr} !== {16'h0010, 16'hBEEF}) begin errors++; $display("FAIL wr_addr_data: got %h expected 0010beef", {xa_addr, xa_data_wr}); end
    req_valid = '0;
    @(negedge clk);
    checks++; if ({grant, xa_wr_s, busy} !== 6'b0) begin errors++; $display("FAIL wr_strobe_len: got %b expected 000000", {grant, xa_wr_s, busy}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL wr_no_rsp: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_single_read();
    set_req(1, 1'b0, 16'h0020, 16'h0000);
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if ({grant, xa_wr_s, xa_rd_s} !== 6'b0010_01) begin errors++; $display("FAIL rd_grant_strobe: got %b expected 001001", {grant, xa_wr_s, xa_rd_s}); end
    checks++; if (xa_addr !== 16'h0020) begin errors++; $display("FAIL rd_addr: got %h expected 0020", xa_addr); end
    req_valid = '0;
    @(negedge clk);
    checks++; if ({xa_rd_s, rsp_valid, busy} !== 6'b0_0000_1) begin errors++; $display("FAIL rd_wait: got %b expected 000001", {xa_rd_s, rsp_valid, busy}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_rsp_valid: got %b expected 0010", rsp_valid); end
    checks++; if (rsp_rdata !== 16'h1234) begin errors++; $display("FAIL rd_rsp_rdata: got %h expected 1234", rsp_rdata); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rd_rsp_pulse: got %b expected 0000", rsp_valid); end
  endtask

  task automatic test_all_after_reset();
    int e;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 16'(16'h0100 + i), 16'(16'hD000 + i));
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      @(negedge clk);
      checks++; if (grant !== 4'(1 << e) || xa_wr_s !== 1'b1 || xa_addr !== 16'(16'h0100 + e))
        begin errors++; $display("FAIL all_grant_%0d: got grant=%b wr=%b addr=%h expected grant=%b wr=1 addr=%h", k, grant, xa_wr_s, xa_addr, 4'(1 << e), 16'(16'h0100 + e)); end
      if (k == 4) req_valid = '0;
      @(negedge clk);
      checks++; if ({grant, xa_wr_s} !== 5'b0) begin errors++; $display("FAIL all_gap_%0d: got %b expected 00000", k, {grant, xa_wr_s}); end
    end
  endtask

  task automatic test_wrap_sparse();
    int exp_seq [3] = '{0, 3, 0};
    set_req(3, 1'b1, 16'h0300, 16'h3333);
    set_req(0, 1'b1, 16'h0200, 16'h0000);
    req_valid = 4'b1000;
    @(negedge clk);
    checks++; if (grant !== 4'b1000) begin errors++; $display("FAIL wrap_setup: got %b expected 1000", grant); end
    req_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      @(negedge clk);
      checks++; if (grant !== 4'(1 << exp_seq[k])) begin errors++; $display("FAIL wrap_grant_%0d: got %b expected %b", k, grant, 4'(1 << exp_seq[k])); end
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read();
    set_req(2, 1'b0, 16'h0030, 16'h0000);
    req_valid = 4'b0100;
    @(negedge clk);
    checks++; if ({grant, xa_rd_s} !== 5'b0100_1) begin errors++; $display("FAIL rst_rd_issue: got %b expected 01001", {grant, xa_rd_s}); end
    req_valid = '0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_rd_wait_busy: got %b expected 1", busy); end
    rst = 1'b1;
    set_req(1, 1'b1, 16'h0011, 16'h1111);
    set_req(3, 1'b1, 16'h0033, 16'h3333);
    req_valid = 4'b1010;
    #1;
    checks++; if ({grant, rsp_valid, xa_wr_s, xa_rd_s, busy} !== 11'b0 || {xa_addr, xa_data_wr, rsp_rdata} !== 48'b0)
      begin errors++; $display("FAIL rst_async_clear: got ctl=%b data=%h expected all zero", {grant, rsp_valid, xa_wr_s, xa_rd_s, busy}, {xa_addr, xa_data_wr, rsp_rdata}); end
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0) begin errors++; $display("FAIL rst_dropped_rsp: got %b expected 0000", rsp_valid); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL rst_first_grant: got %b expected 0010", grant); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    set_req(0, 1'b1, 16'h0001, 16'hA5C3);
    set_req(1, 1'b0, 16'h0001, 16'h0000);
    req_valid = 4'b0011;
    @(negedge clk);
    checks++; if ({grant, xa_wr_s, xa_rd_s} !== 6'b0001_10 || xa_data_wr !== 16'hA5C3)
      begin errors++; $display("FAIL b2b_write: got %b data=%h expected 000110 data=a5c3", {grant, xa_wr_s, xa_rd_s}, xa_data_wr); end
    req_valid = 4'b0010;
    @(negedge clk);
    checks++; if ({grant, xa_wr_s, xa_rd_s} !== 6'b0) begin errors++; $display("FAIL b2b_gap: got %b expected 000000", {grant, xa_wr_s, xa_rd_s}); end
    @(negedge clk);
    checks++; if ({grant, xa_wr_s, xa_rd_s} !== 6'b0010_01 || xa_addr !== 16'h0001)
      begin errors++; $display("FAIL b2b_read: got %b addr=%h expected 001001 addr=0001", {grant, xa_wr_s, xa_rd_s}, xa_addr); end
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 4'b0010 || rsp_rdata !== 16'hA5C3)
      begin errors++; $display("FAIL b2b_rsp: got valid=%b data=%h expected valid=0010 data=a5c3", rsp_valid, rsp_rdata); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_all_after_reset();
    test_wrap_sparse();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
